fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 33 +++
 rtl/fetch_unit_next_pc.sv | 30 +++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg
// Declarations shared by the fetch unit and the control decoder:
//   - fetch FSM state encoding
//   - default reset PC
//   - opcode constants
//   - small PC arithmetic helpers
package fetch_unit_pkg;

  typedef enum logic [0:0] {
    S_REQ  = 1'b0,  // requesting a word from instruction memory
    S_HOLD = 1'b1   // holding a word until decode accepts it
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] INSTR_BYTES      = 32'd4;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Word offset to byte offset. Bits shifted out of the top are
  // intentionally lost, because PC arithmetic wraps modulo 2^32.
  function automatic logic [31:0] word_offset(input logic [31:0] off);
    return {off[29:0], 2'b00};
  endfunction

  // Extract the opcode field of an instruction word.
  function automatic logic [5:0] opcode_of(input logic [31:0] word);
    return word[31:26];
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// fetch_unit_next_pc
// Combinational next-PC selection for the fetch unit.
// Inputs:
//   pc_instr      - address the current instruction was fetched from
//   branch_taken  - branch & zero for that instruction
//   branch_offset - sign-extended word offset
// Output:
//   next_pc       - pc_instr + 4, or pc_instr + 4 + (branch_offset << 2) when taken
module fetch_unit_next_pc
  import fetch_unit_pkg::*;
(
  input  logic [31:0] pc_instr,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  output logic [31:0] next_pc
);

  logic [31:0] seq_pc_s;

  // Sequential or branch target; every add wraps naturally at 32 bits.
  always_comb begin
    seq_pc_s = pc_instr + INSTR_BYTES;
    if (branch_taken) begin
      next_pc = seq_pc_s + word_offset(branch_offset);
    end else begin
      next_pc = seq_pc_s;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit
// Two-state instruction fetch.
// The unit requests the word at PC from instruction memory, then holds the
// returned word in the instruction register until decode accepts it. On
// acceptance it computes the next PC, taking a branch if needed, and counts
// the instruction.
// Ports:
//   clk, reset                   - clock, synchronous active-high reset
//   imem_req/imem_addr           - memory read request and word byte address
//   imem_ack/imem_data           - memory response
//   instr_valid/instr_ready      - handshake with decode
//   instr, op, pc_instr          - held instruction, its opcode, and its fetch address
//   branch, zero, branch_offset  - branch resolution, sampled on the handshake only
//   fetch_count                  - number of accepted instructions (wraps)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  op,
  output logic [31:0] pc_instr,
  input  logic        branch,
  input  logic        zero,
  input  logic [31:0] branch_offset,
  output logic [31:0] fetch_count
);

  fetch_state_t state_r;
  logic         imem_req_r;
  logic         instr_valid_r;
  logic [31:0]  pc_r;
  logic [31:0]  instr_r;
  logic [31:0]  pc_instr_r;
  logic [31:0]  fetch_count_r;
  logic [31:0]  next_pc_s;
  logic         branch_taken_s;

  // Branch qualifier. It only matters when the handshake occurs.
  always_comb begin
    branch_taken_s = branch & zero;
  end

  fetch_unit_next_pc u_next_pc (
    .pc_instr      (pc_instr_r),
    .branch_taken  (branch_taken_s),
    .branch_offset (branch_offset),
    .next_pc       (next_pc_s)
  );

  // Fetch FSM with registered request/valid flags and datapath registers.
  // Reset is checked first, so it overrides any ack or handshake in the
  // same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= S_REQ;
      imem_req_r    <= 1'b1;
      instr_valid_r <= 1'b0;
      pc_r          <= RESET_PC;
      instr_r       <= 32'h0000_0000;
      pc_instr_r    <= 32'h0000_0000;
      fetch_count_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_REQ: begin
          if (imem_ack) begin
            instr_r       <= imem_data;
            pc_instr_r    <= pc_r;
            state_r       <= S_HOLD;
            imem_req_r    <= 1'b0;
            instr_valid_r <= 1'b1;
          end else begin
            state_r <= S_REQ;
          end
        end
        S_HOLD: begin
          if (instr_ready) begin
            pc_r          <= next_pc_s;
            fetch_count_r <= fetch_count_r + 32'd1;
            state_r       <= S_REQ;
            imem_req_r    <= 1'b1;
            instr_valid_r <= 1'b0;
          end else begin
            state_r <= S_HOLD;
          end
        end
        default: begin
          state_r       <= S_REQ;
          imem_req_r    <= 1'b1;
          instr_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_r;
  assign imem_addr   = pc_r;
  assign instr_valid = instr_valid_r;
  assign instr       = instr_r;
  assign op          = opcode_of(instr_r);
  assign pc_instr    = pc_instr_r;
  assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit.
// Two instances share all inputs: one uses the default RESET_PC, the other
// uses 0xFFFF_FFFC so the PC wrap case is exercised. A transaction-level
// model predicts every output each cycle, and directed literal checks pin
// the model to hand-computed values.
module tb_fetch_unit;

  localparam logic [31:0] PC_B = 32'hFFFF_FFFC;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, imem_ack, instr_ready, branch, zero;
  logic [31:0] imem_data, branch_offset;

  logic        a_imem_req, a_instr_valid, b_imem_req, b_instr_valid;
  logic [31:0] a_imem_addr, a_instr, a_pc_instr, a_fetch_count;
  logic [31:0] b_imem_addr, b_instr, b_pc_instr, b_fetch_count;
  logic [5:0]  a_op, b_op;

  fetch_unit dut_a (
    .clk(clk), .reset(reset), .imem_req(a_imem_req), .imem_addr(a_imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr_valid(a_instr_valid),
    .instr_ready(instr_ready), .instr(a_instr), .op(a_op), .pc_instr(a_pc_instr),
    .branch(branch), .zero(zero), .branch_offset(branch_offset),
    .fetch_count(a_fetch_count)
  );

  fetch_unit #(.RESET_PC(PC_B)) dut_b (
    .clk(clk), .reset(reset), .imem_req(b_imem_req), .imem_addr(b_imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data), .instr_valid(b_instr_valid),
    .instr_ready(instr_ready), .instr(b_instr), .op(b_op), .pc_instr(b_pc_instr),
    .branch(branch), .zero(zero), .branch_offset(branch_offset),
    .fetch_count(b_fetch_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Transaction-level model.
  // The unit either waits for a word or holds one. The PC of each
  // instance advances only when decode accepts the held word.
  bit          m_live = 1'b0;
  bit          m_have_word;
  logic [31:0] m_word, m_count;
  logic [31:0] m_pc  [2];
  logic [31:0] m_from[2];

  always @(posedge clk) begin
    if (reset) begin
      m_live      = 1'b1;
      m_have_word = 1'b0;
      m_word      = 32'd0;
      m_count     = 32'd0;
      m_pc[0]     = 32'd0;
      m_pc[1]     = PC_B;
      m_from[0]   = 32'd0;
      m_from[1]   = 32'd0;
    end else if (m_live && !m_have_word && imem_ack) begin
      m_have_word = 1'b1;
      m_word      = imem_data;
      m_from[0]   = m_pc[0];
      m_from[1]   = m_pc[1];
    end else if (m_live && m_have_word && instr_ready) begin
      m_have_word = 1'b0;
      m_count     = m_count + 32'd1;
      for (int i = 0; i < 2; i++)
        m_pc[i] = m_from[i] + 32'd4 + ((branch && zero) ? branch_offset * 32'd4 : 32'd0);
    end
  end

  // Compare every output of both instances with the model each cycle.
  always @(negedge clk) begin
    if (m_live) begin
      chk("a_req",   {31'd0, a_imem_req},    {31'd0, !m_have_word});
      chk("a_addr",  a_imem_addr,            m_pc[0]);
      chk("a_valid", {31'd0, a_instr_valid}, {31'd0, m_have_word});
      chk("a_instr", a_instr,                m_word);
      chk("a_op",    {26'd0, a_op},          {26'd0, m_word[31:26]});
      chk("a_pci",   a_pc_instr,             m_from[0]);
      chk("a_cnt",   a_fetch_count,          m_count);
      chk("b_req",   {31'd0, b_imem_req},    {31'd0, !m_have_word});
      chk("b_addr",  b_imem_addr,            m_pc[1]);
      chk("b_valid", {31'd0, b_instr_valid}, {31'd0, m_have_word});
      chk("b_instr", b_instr,                m_word);
      chk("b_pci",   b_pc_instr,             m_from[1]);
      chk("b_cnt",   b_fetch_count,          m_count);
    end
  end

  // One fetch and accept, starting at a negedge while requesting.
  // Branch inputs carry junk during hold cycles; that junk must be ignored.
  task automatic xfer(input logic [31:0] data, input int dly, input int hold,
                      input logic br, input logic z, input logic [31:0] off);
    repeat (dly) @(negedge clk);
    imem_ack = 1'b1; imem_data = data;
    @(negedge clk);
    imem_ack = 1'b0;
    branch = 1'b1; zero = 1'b1; branch_offset = 32'h0000_0100;
    repeat (hold) @(negedge clk);
    instr_ready = 1'b1; branch = br; zero = z; branch_offset = off;
    @(negedge clk);
    instr_ready = 1'b0; branch = 1'b0; zero = 1'b0; branch_offset = 32'h0;
  endtask

  initial begin
    reset = 1'b1; imem_ack = 1'b0; instr_ready = 1'b0; branch = 1'b0; zero = 1'b0;
    imem_data = 32'h0; branch_offset = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_req",   {31'd0, a_imem_req},    32'd1);
    chk("rst_addr",  a_imem_addr,            32'h0);
    chk("rst_addrb", b_imem_addr,            32'hFFFF_FFFC);
    chk("rst_valid", {31'd0, a_instr_valid}, 32'd0);
    chk("rst_op",    {26'd0, a_op},          32'd0);

    // Ack in the first request cycle.
    reset = 1'b0; imem_ack = 1'b1; imem_data = 32'h8C01_0004;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("lw_valid", {31'd0, a_instr_valid}, 32'd1);
    chk("lw_op",    {26'd0, a_op},          32'h23);
    chk("lw_pci",   a_pc_instr,             32'h0);

    // Stall 4 cycles; a stray ack during the hold must be ignored.
    imem_ack = 1'b1; imem_data = 32'hDEAD_BEEF;
    repeat (4) @(negedge clk);
    imem_ack = 1'b0;
    chk("stall_instr", a_instr,       32'h8C01_0004);
    chk("stall_cnt",   a_fetch_count, 32'd0);
    chk("stall_req",   {31'd0, a_imem_req}, 32'd0);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("acc_cnt",   a_fetch_count, 32'd1);
    chk("acc_addr",  a_imem_addr,   32'h4);
    chk("wrap_addr", b_imem_addr,   32'h0);

    // Ack delayed by 3 cycles: request and address must stay put.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("dly_req",  {31'd0, a_imem_req}, 32'd1);
      chk("dly_addr", a_imem_addr, 32'h4);
    end
    imem_ack = 1'b1; imem_data = 32'h0000_0020;
    @(negedge clk);
    imem_ack = 1'b0;
    chk("dly_pci", a_pc_instr, 32'h4);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;

    xfer(32'h8C02_0008, 0, 1, 1'b0, 1'b0, 32'h0);          // 8 -> C
    xfer(32'hAC03_000C, 1, 0, 1'b0, 1'b0, 32'h0);          // C -> 10
    xfer(32'h1000_FFFD, 0, 0, 1'b1, 1'b1, 32'hFFFF_FFFD);  // beq taken
    chk("beq_taken", a_imem_addr, 32'h8);
    xfer(32'h0000_0020, 0, 0, 1'b0, 1'b0, 32'h0);          // 8 -> C
    xfer(32'h0000_0020, 0, 0, 1'b0, 1'b0, 32'h0);          // C -> 10
    xfer(32'h1000_FFFD, 0, 0, 1'b1, 1'b0, 32'hFFFF_FFFD);  // zero = 0
    chk("beq_not", a_imem_addr, 32'h14);
    xfer(32'h0000_0020, 0, 2, 1'b0, 1'b1, 32'h10);         // branch = 0
    chk("nobr", a_imem_addr, 32'h18);
    xfer(32'h1000_0002, 0, 0, 1'b1, 1'b1, 32'h2);          // forward branch
    chk("fwd", a_imem_addr, 32'h24);
    chk("cnt10", a_fetch_count, 32'd10);

    // Reset while holding, with a handshake and a taken branch pending.
    imem_ack = 1'b1; imem_data = 32'h1234_5678;
    @(negedge clk);
    imem_ack = 1'b0;
    reset = 1'b1; instr_ready = 1'b1; branch = 1'b1; zero = 1'b1;
    @(negedge clk);
    reset = 1'b0; instr_ready = 1'b0; branch = 1'b0; zero = 1'b0;
    chk("hrst_cnt",   a_fetch_count, 32'd0);
    chk("hrst_addr",  a_imem_addr,   32'h0);
    chk("hrst_valid", {31'd0, a_instr_valid}, 32'd0);

    // Reset during a request, with an ack in the same cycle.
    reset = 1'b1; imem_ack = 1'b1; imem_data = 32'hFFFF_FFFF;
    @(negedge clk);
    reset = 1'b0; imem_ack = 1'b0;
    chk("rrst_valid", {31'd0, a_instr_valid}, 32'd0);
    chk("rrst_instr", a_instr, 32'h0);

    xfer(32'h8C01_0004, 0, 0, 1'b0, 1'b0, 32'h0);
    chk("end_cnt",  a_fetch_count, 32'd1);
    chk("end_addr", b_imem_addr,   32'h0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
